sos_led_module: RTL

Morse "SOS" pattern generator that sits directly downstream of the periodic SOS enable timer. On each single-cycle `SOS_En` pulse it drives `LED_Out` through one complete S-O-S sequence: three dots, three dashes, three dots, with intra-letter and inter-letter gaps. It then returns to idle and emits a one-cycle `Done` pulse. All durations are parameters in `CLK` cycles; defaults assume a 50 MHz clock.

---
 rtl/sos_led_module.sv | 112 +++++++++++
 1 files changed

// File: rtl/sos_led_module.sv
// Morse "SOS" LED sequencer: one S-O-S pattern per SOS_En pulse, then a one-cycle Done.
// All mark/gap durations are parameters counted in CLK cycles.
module sos_led_module #(
    parameter int T_DOT    = 25_000_000,
    parameter int T_DASH   = 75_000_000,
    parameter int T_GAP    = 25_000_000,
    parameter int T_LETTER = 75_000_000,
    parameter int CW       = 27
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic SOS_En,
    output logic LED_Out,
    output logic Busy,
    output logic Done
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    localparam logic [3:0] LAST_IDX = 4'd8;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            led_q, led_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mark_end, space_end;

    // Terminal count of the mark for element i: dashes are the middle letter.
    function automatic logic [CW-1:0] mark_last(input logic [3:0] i);
        if (i >= 4'd3 && i <= 4'd5) return CW'(T_DASH - 1);
        return CW'(T_DOT - 1);
    endfunction

    // Terminal count of the gap after element i: letter gap closes S and O.
    function automatic logic [CW-1:0] gap_last(input logic [3:0] i);
        if (i == 4'd2 || i == 4'd5) return CW'(T_LETTER - 1);
        return CW'(T_GAP - 1);
    endfunction

    assign mark_end  = (state_q == MARK)  && (cnt_q == mark_last(idx_q));
    assign space_end = (state_q == SPACE) && (cnt_q == gap_last(idx_q));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (SOS_En) begin
                    state_d = MARK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            MARK: begin
                if (mark_end) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = SPACE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SPACE: begin
                if (space_end) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 4'd1;
                    state_d = MARK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        led_d  = (state_d == MARK);
        busy_d = (state_d != IDLE);
        done_d = mark_end && (idx_q == LAST_IDX);
    end

    assign LED_Out = led_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule
